// File: rtl/fft_out_reorder.sv
// fft_out_reorder: captures bit-reversed FFT frames into a ping-pong buffer
// and replays them in natural bin order over a valid/ready handshake.
// Drops whole frames when both banks are busy; ovf and sync_err are sticky.
// Optional: define FFT_REORDER_DROP_CNT_EN to add the drop_cnt output.
module fft_out_reorder #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3,
    parameter int DW       = 34
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_sof,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_sof,
    output logic          dout_eof,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic          sync_err
`ifdef FFT_REORDER_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_OUT} rstate_t;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // Two banks of N_POINTS words; bank select is the address MSB.
    logic [DW-1:0]    r_mem [0:2*N_POINTS-1];
    bank_st_t         r_bank_st [0:1];

    wstate_t          r_wstate, w_wstate_nxt;
    logic [LOG2N-1:0] r_wcnt, w_wcnt_nxt;
    logic             r_wbank, w_wbank_nxt;
    logic             w_we;
    logic [LOG2N-1:0] w_waddr;
    logic             w_wb_fill, w_wb_full, w_set_ovf, w_set_sync, w_drop_start;
    logic             w_wb_free;

    rstate_t          r_rstate, w_rstate_nxt;
    logic [LOG2N-1:0] r_rcnt, w_rcnt_nxt;
    logic             r_rbank, w_rbank_nxt;
    logic             w_rd_start, w_rd_done, w_load, w_xfer;

    logic [DW-1:0]    r_dout;
    logic             r_dout_valid, r_dout_sof, r_dout_eof;
    logic             r_ovf, r_sync_err;

    // Write FSM next-state: store, drop, or resynchronise on din_sof.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_wbank_nxt  = r_wbank;
        w_we         = 1'b0;
        w_waddr      = bitrev(r_wcnt);
        w_wb_fill    = 1'b0;
        w_wb_full    = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_sync   = 1'b0;
        w_drop_start = 1'b0;
        // A bank we are currently filling is abandoned on a mid-frame sof,
        // so it counts as free for the restart in the same cycle.
        w_wb_free    = (r_bank_st[r_wbank] == B_EMPTY) || (r_wstate == W_FILL);
        if (din_valid) begin
            if (din_sof) begin
                if (r_wstate != W_IDLE) w_set_sync = 1'b1;
                w_wcnt_nxt = ONE;
                if (w_wb_free) begin
                    w_we         = 1'b1;
                    w_waddr      = '0;
                    w_wb_fill    = 1'b1;
                    w_wstate_nxt = W_FILL;
                end else begin
                    w_set_ovf    = 1'b1;
                    w_drop_start = 1'b1;
                    w_wstate_nxt = W_DROP;
                end
            end else begin
                case (r_wstate)
                    W_FILL: begin
                        w_we       = 1'b1;
                        w_wcnt_nxt = r_wcnt + ONE;
                        if (r_wcnt == LAST) begin
                            w_wb_full    = 1'b1;
                            w_wbank_nxt  = ~r_wbank;
                            w_wstate_nxt = W_IDLE;
                        end
                    end
                    W_DROP: begin
                        w_wcnt_nxt = r_wcnt + ONE;
                        if (r_wcnt == LAST) w_wstate_nxt = W_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read FSM next-state: claim a FULL bank, then stream it gap-free.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        w_rbank_nxt  = r_rbank;
        w_rd_start   = 1'b0;
        w_rd_done    = 1'b0;
        w_load       = 1'b0;
        w_xfer       = r_dout_valid & dout_ready;
        case (r_rstate)
            R_IDLE: begin
                if (r_bank_st[r_rbank] == B_FULL) begin
                    w_rd_start   = 1'b1;
                    w_rcnt_nxt   = '0;
                    w_rstate_nxt = R_LOAD;
                end
            end
            R_LOAD: begin
                w_load       = 1'b1;
                w_rstate_nxt = R_OUT;
            end
            R_OUT: begin
                if (w_xfer) begin
                    if (r_rcnt != LAST) begin
                        w_rcnt_nxt = r_rcnt + ONE;
                        w_load     = 1'b1;
                    end else begin
                        w_rd_done    = 1'b1;
                        w_rbank_nxt  = ~r_rbank;
                        w_rstate_nxt = R_IDLE;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // FSM state, counters and bank pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_wbank  <= 1'b0;
            r_rstate <= R_IDLE;
            r_rcnt   <= '0;
            r_rbank  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_wbank  <= w_wbank_nxt;
            r_rstate <= w_rstate_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_rbank  <= w_rbank_nxt;
        end
    end

    // Per-bank lifecycle; each FSM only ever touches its own bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st[0] <= B_EMPTY;
            r_bank_st[1] <= B_EMPTY;
        end else begin
            if (w_wb_fill)  r_bank_st[r_wbank] <= B_FILLING;
            if (w_wb_full)  r_bank_st[r_wbank] <= B_FULL;
            if (w_rd_start) r_bank_st[r_rbank] <= B_DRAINING;
            if (w_rd_done)  r_bank_st[r_rbank] <= B_EMPTY;
        end
    end

    // Sample storage at bit-reversed addresses; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[{r_wbank, w_waddr}] <= din;
    end

    // Registered output word and frame markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
            r_dout_eof   <= 1'b0;
        end else if (w_load) begin
            r_dout       <= r_mem[{r_rbank, w_rcnt_nxt}];
            r_dout_valid <= 1'b1;
            r_dout_sof   <= (w_rcnt_nxt == '0);
            r_dout_eof   <= (w_rcnt_nxt == LAST);
        end else if (w_rd_done) begin
            r_dout_valid <= 1'b0;
            r_dout_sof   <= 1'b0;
            r_dout_eof   <= 1'b0;
        end
    end

    // Sticky error flags; a new event in the clear cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_set_ovf)    r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
            if (w_set_sync)   r_sync_err <= 1'b1;
            else if (ovf_clr) r_sync_err <= 1'b0;
        end
    end

`ifdef FFT_REORDER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_drop_cnt <= w_drop_start ? 8'd1 : 8'd0;
        end else if (w_drop_start && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_sof   = r_dout_sof;
    assign dout_eof   = r_dout_eof;
    assign ovf        = r_ovf;
    assign sync_err   = r_sync_err;

endmodule
